// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
//   skid_state_e : occupancy state of the two-entry skid buffer
//   *_t          : packed payload layout for each stage boundary
//   *_W          : payload widths, used as DATA_W when instantiating
//                  pipe_stage_reg at each boundary
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  wb_rd;
    logic        zero;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] mem_rd;
    logic [4:0]  wb_rd;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk : rising-edge clock
//   i_clr : synchronous clear to zero (wins over i_inc)
//   i_inc : increment enable; the count sticks at all-ones
//   o_cnt : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop every held entry (squash)
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   stall_cnt  : saturating count of cycles with out_valid=1, out_ready=0
// SKID=1 gives a two-entry buffer whose in_ready comes straight from a
// flop; SKID=0 gives a single entry with combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_WB_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_in_ready;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_accept;
  logic              w_emit;

  assign w_accept = in_valid && w_in_ready;
  assign w_emit   = w_out_valid && out_ready;

  if (SKID != 0) begin : g_skid
    skid_state_e       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;

    // r_in_ready tracks (next state != TWO) so the upstream sees a pure
    // flop; the skid entry catches the one payload in flight when the
    // downstream stalls.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_state    <= EMPTY;
        r_main     <= '0;
        r_skid     <= '0;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_state <= ONE;
              r_main  <= in_data;
            end
          end
          ONE: begin
            if (w_accept && !w_emit) begin
              r_state    <= TWO;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
            end else if (w_emit && !w_accept) begin
              r_state <= EMPTY;
            end else if (w_accept && w_emit) begin
              r_main <= in_data;
            end
          end
          TWO: begin
            if (w_emit) begin
              r_state    <= ONE;
              r_main     <= r_skid;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end

    assign w_in_ready  = r_in_ready;
    assign w_out_valid = (r_state != EMPTY);
    assign w_out_data  = r_main;
  end else begin : g_single
    logic              r_valid;
    logic [DATA_W-1:0] r_main;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_main  <= in_data;
      end else if (w_emit) begin
        r_valid <= 1'b0;
      end
    end

    assign w_in_ready  = !r_valid || out_ready;
    assign w_out_valid = r_valid;
    assign w_out_data  = r_main;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_out_valid && !out_ready),
    .o_cnt (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, a synchronous flush, and a saturating stall-cycle counter. It is the next-generation inter-stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB): one instance per stage boundary, carrying the whole stage payload as a single packed word. It replaces per-stage fixed-width registers with an enable input by backpressure-driven flow control.

## Interface
- DATA_W, 69 — payload width; 69 = MEM/WB payload (32 + 32 + 5).
- SKID, 1 — 1: two-entry skid buffer with registered in_ready; 0: single entry, in_ready combinational.
- CNT_W, 16 — stall counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/exception squash).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head payload.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturates.

## Operation
- Accept: in_valid && in_ready at a clock edge. Emit: out_valid && out_ready at a clock edge.
- SKID=1 state machine (enum EMPTY, ONE, TWO):
  - EMPTY: accept -> ONE; main register <= in_data.
  - ONE: accept without emit -> TWO (skid <= in_data). Emit without accept -> EMPTY. Both -> ONE (main <= in_data). Neither -> ONE.
  - TWO: in_ready=0. Emit -> ONE (main <= skid). Otherwise hold.
  - out_valid = (state != EMPTY). out_data = main register. in_ready = (state != TWO), driven from a flop.
- SKID=0: one entry. in_ready = !out_valid || out_ready (combinational). Accept and emit in the same cycle replace the entry.
- Ordering is strictly FIFO. No payload is duplicated or dropped, except on flush or rst.
- Flush has priority over accept and emit:
  - Next state is EMPTY and both data registers go to 0.
  - A payload offered during the flush cycle is discarded.
  - A downstream emit in that cycle still completes; downstream sees out_valid=1 in that cycle.
- stall_cnt increments when out_valid && !out_ready, holds at 2^CNT_W−1, and is cleared only by rst. Flush does not clear it.
- rst overrides flush and sets every output to its reset value.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0, state EMPTY. in_ready=1 from the first cycle after the rst edge (in both SKID modes).
- Latency: payload accepted at edge N appears on out_data/out_valid after edge N (one cycle).
- Throughput: one payload per cycle, sustained while out_ready=1.
- SKID=1: in_ready has no combinational path from out_ready. The full stall takes effect one cycle late, and the skid entry absorbs that in-flight payload.
- Deassert of out_ready with ONE and accept -> TWO. in_ready goes to 0 after that edge.
- Reassert of out_ready in TWO: emit main, skid moves to main, in_ready returns to 1 after the edge.
- Flush during TWO: both entries are dropped and in_ready=1 on the next cycle.
- rst asserted mid-stream: all entries are lost at that edge. No partial state survives.

## Structure
- Shared package pipe_pkg:
  - skid state enum typedef (EMPTY/ONE/TWO).
  - Packed payload structs per boundary (if_id_t, id_ex_t, ex_mem_t, mem_wb_t = {alu_res[31:0], mem_rd[31:0], wb_rd[4:0]}).
  - Width constants derived with $bits, used for DATA_W at instantiation.
- One sub-module: sat_counter (parametrised width, synchronous clear, increment enable), used for stall_cnt.
- Everything else stays inline. SKID is selected with a generate branch.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1, in_data=0x1_2345_6789 -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 after release.
- Streaming: SKID=1, out_ready=1, push 0x01..0x10 on consecutive cycles -> same sequence on out_data, one-cycle latency, no bubbles.
- Backpressure: SKID=1, drop out_ready after 0x01 is emitted while pushing 0x02,0x03,0x04:
  - Expected: state TWO holding 0x02/0x03 and in_ready=0, with 0x04 held upstream.
  - After 3 stalled cycles stall_cnt=3.
  - Restoring out_ready yields 0x02,0x03,0x04 in order.
- Flush: in state TWO, assert flush together with in_valid=1 / 0x55 -> next cycle out_valid=0, out_data=0, in_ready=1. 0x55 never appears.
- SKID=0 pass-through: with out_valid=1, out_ready=1, in_valid=1, check that in_ready=1 in the same cycle and the entry is replaced. With out_ready=0, check that in_ready=0 in the same cycle.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
